// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two requesters (0 = CPU, 1 = DMA/debug) and the memory.
// The slave modport is the arbiter's view; master is the requesters' and memory's side.
interface mem_arbiter_if;
   logic        req0;
   logic        we0;
   logic [31:0] addr0;
   logic [31:0] wdata0;
   logic [3:0]  bmask0;
   logic        gnt0;
   logic        rvalid0;
   logic [31:0] rdata0;

   logic        req1;
   logic        we1;
   logic [31:0] addr1;
   logic [31:0] wdata1;
   logic [3:0]  bmask1;
   logic        gnt1;
   logic        rvalid1;
   logic [31:0] rdata1;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_bmask;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        busy;

   modport slave (
      input  req0, we0, addr0, wdata0, bmask0,
      output gnt0, rvalid0, rdata0,
      input  req1, we1, addr1, wdata1, bmask1,
      output gnt1, rvalid1, rdata1,
      output mem_addr, mem_wdata, mem_bmask, mem_we,
      input  mem_rdata,
      output busy
   );

   modport master (
      output req0, we0, addr0, wdata0, bmask0,
      input  gnt0, rvalid0, rdata0,
      output req1, we1, addr1, wdata1, bmask1,
      input  gnt1, rvalid1, rdata1,
      input  mem_addr, mem_wdata, mem_bmask, mem_we,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE grants one requester, ISSUE drives the memory, WAIT returns read data.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin on ties; otherwise requester 0 has fixed priority.
module mem_arbiter (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  bmask_q;
   logic        we_q;
   logic        win_q;
   logic        win_d;
   logic        grant;

   // Grant is suppressed while reset is held so no requester sees a phantom accept.
   assign grant = (state_q == StIdle) && (bus.req0 || bus.req1) && !reset;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic last_q;

   always_comb begin
      if (bus.req0 && bus.req1) win_d = ~last_q;
      else                      win_d = bus.req1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      last_q <= 1'b1;
      else if (grant) last_q <= win_d;
   end
`else
   assign win_d = ~bus.req0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant) state_d = StIssue;
         StIssue: state_d = we_q ? StIdle : StWait;
         StWait:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Request fields are captured only on the grant edge and held until the next grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         bmask_q <= '0;
         we_q    <= 1'b0;
         win_q   <= 1'b0;
      end else if (grant) begin
         addr_q  <= win_d ? bus.addr1  : bus.addr0;
         wdata_q <= win_d ? bus.wdata1 : bus.wdata0;
         bmask_q <= win_d ? bus.bmask1 : bus.bmask0;
         we_q    <= win_d ? bus.we1    : bus.we0;
         win_q   <= win_d;
      end
   end

   always_comb begin
      bus.gnt0      = grant && !win_d;
      bus.gnt1      = grant && win_d;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_bmask = bmask_q;
      bus.mem_we    = (state_q == StIssue) && we_q;
      bus.rvalid0   = (state_q == StWait) && !win_q;
      bus.rvalid1   = (state_q == StWait) && win_q;
      bus.rdata0    = bus.rvalid0 ? bus.mem_rdata : '0;
      bus.rdata1    = bus.rvalid1 ? bus.mem_rdata : '0;
      bus.busy      = (state_q != StIdle);
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model queues expected grant/write/read
// events with their cycle stamps; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;
   localparam int KGnt = 0;
   localparam int KWr  = 1;
   localparam int KRv  = 2;

   typedef struct {
      int          cyc;
      int          kind;
      logic        who;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] data;
      logic [3:0]  bmask;
   } ev_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          free_cyc = 0;
   logic        last_w   = 1'b1;
   logic        exp_busy = 1'b0;
   bit          run      = 1'b0;
   logic [31:0] rd_seed  = '0;
   ev_t         sb[$];

   function automatic logic [31:0] rd_at(int c);
      if (rd_seed == 0) return 32'hDEADBEEF;
      return (32'(c) * 32'h9E3779B1) ^ rd_seed;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // One clock of stimulus plus the reference model's view of that cycle.
   task automatic drive(input logic rst,
                        input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic [3:0] m0,
                        input logic r1, input logic w1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic [3:0] m1);
      ev_t  e;
      logic w;
      @(posedge clk);
      #1;
      cyc++;
      reset      = rst;
      bus.req0   = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0; bus.bmask0 = m0;
      bus.req1   = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.bmask1 = m1;
      bus.mem_rdata = rd_at(cyc);
      if (rst) begin
         while (sb.size() > 0 && sb[$].cyc >= cyc) void'(sb.pop_back());
         free_cyc = 0;
         last_w   = 1'b1;
         exp_busy = 1'b0;
      end else begin
         exp_busy = (cyc < free_cyc);
         if (!exp_busy && (r0 || r1)) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            if (r0 && r1) w = (last_w == 1'b0);
            else          w = r1;
`else
            w = !r0;
`endif
            last_w  = w;
            e.who   = w;
            e.addr  = w ? a1 : a0;
            e.wdata = w ? d1 : d0;
            e.bmask = w ? m1 : m0;
            e.data  = '0;
            e.cyc   = cyc;
            e.kind  = KGnt;
            sb.push_back(e);
            if (w ? w1 : w0) begin
               e.cyc  = cyc + 1;
               e.kind = KWr;
               free_cyc = cyc + 2;
            end else begin
               e.cyc  = cyc + 2;
               e.kind = KRv;
               e.data = rd_at(cyc + 2);
               free_cyc = cyc + 3;
            end
            sb.push_back(e);
         end
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
   endtask

   always @(negedge clk) begin
      if (run) begin
         ev_t  e;
         logic obs;
         int   okind;
         obs   = bus.gnt0 | bus.gnt1 | bus.mem_we | bus.rvalid0 | bus.rvalid1;
         okind = (bus.gnt0 | bus.gnt1) ? KGnt : (bus.mem_we ? KWr : KRv);
         while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("event_present", 32'(obs), 32'd1);
            if (obs) begin
               chk("event_kind", 32'(okind), 32'(e.kind));
               case (e.kind)
                  KGnt: chk("gnt_vec", 32'({bus.gnt1, bus.gnt0}), e.who ? 32'd2 : 32'd1);
                  KWr: begin
                     chk("wr_addr", bus.mem_addr, e.addr);
                     chk("wr_wdata", bus.mem_wdata, e.wdata);
                     chk("wr_bmask", 32'(bus.mem_bmask), 32'(e.bmask));
                  end
                  default: begin
                     chk("rvalid_vec", 32'({bus.rvalid1, bus.rvalid0}), e.who ? 32'd2 : 32'd1);
                     chk("rdata0", bus.rdata0, e.who ? 32'd0 : e.data);
                     chk("rdata1", bus.rdata1, e.who ? e.data : 32'd0);
                     chk("rd_addr", bus.mem_addr, e.addr);
                     chk("rd_mem_we", 32'(bus.mem_we), 32'd0);
                  end
               endcase
            end
         end else begin
            chk("no_event", 32'(obs), 32'd0);
         end
         chk("busy", 32'(bus.busy), 32'(exp_busy));
      end
   end

   initial begin
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.bmask0 = '0;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.bmask1 = '0;
      bus.mem_rdata = '0;
      @(negedge clk);
      chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
      chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
      chk("rst_rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_mem_bmask", 32'(bus.mem_bmask), 32'd0);
      run = 1'b1;

      // Single read on port 0, then single write on port 1.
      drive(0, 1, 0, 32'h100, '0, 4'hF, 0, 0, '0, '0, '0);
      idle(3);
      drive(0, 0, 0, '0, '0, '0, 1, 1, 32'h200, 32'h12345678, 4'hF);
      idle(3);

      // Both ports hold reads for 9 cycles.
      for (int i = 0; i < 9; i++) drive(0, 1, 0, 32'h300, '0, 4'h3, 1, 0, 32'h400, '0, 4'hC);
      idle(3);

      // Back-to-back writes from port 0, one with an empty byte mask.
      for (int i = 0; i < 6; i++)
         drive(0, 1, 1, 32'h40 + 32'(i), 32'hA5A50000 + 32'(i), (i == 3) ? 4'h0 : 4'h5,
               0, 0, '0, '0, '0);
      idle(2);

      // Reset while a read is in ISSUE; port 1 requests across the reset.
      drive(0, 1, 0, 32'h500, '0, 4'hF, 0, 0, '0, '0, '0);
      drive(1, 0, 0, '0, '0, '0, 1, 0, 32'h600, '0, 4'hF);
      drive(0, 0, 0, '0, '0, '0, 1, 0, 32'h600, '0, 4'hF);
      idle(4);

      // Port 1 pulses a write request only while the arbiter is busy.
      drive(0, 1, 0, 32'h700, '0, 4'hF, 0, 0, '0, '0, '0);
      drive(0, 0, 0, '0, '0, '0, 1, 1, 32'h800, 32'h55, 4'hF);
      idle(4);

      rd_seed = $urandom | 32'd1;
      for (int i = 0; i < 400; i++) begin
         logic rr;
         rr = ($urandom_range(0, 99) < 2);
         drive(rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      idle(4);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
